// File: rtl/car_draw_scheduler.sv
// car_draw_scheduler: round-robin EN sequencer for car sprite engines.
// Serves each engine once per frame and muxes its pixel bus to the VGA side.
module car_draw_scheduler #(
   parameter int          NUM_CARS = 4,
   parameter logic [23:0] TIMEOUT  = 24'd200000
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [NUM_CARS-1:0]   finish_in,
   input  logic [NUM_CARS-1:0]   plot_in,
   input  logic [8*NUM_CARS-1:0] x_in,
   input  logic [7*NUM_CARS-1:0] y_in,
   input  logic [3*NUM_CARS-1:0] colour_in,
   output logic [NUM_CARS-1:0]   en_out,
   output logic                  plot,
   output logic [7:0]            x,
   output logic [6:0]            y,
   output logic [2:0]            colour,
   output logic [2:0]            active_idx,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  timeout_err
);

   localparam int IW = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CARS - 1);
   localparam logic [23:0]   WD_LIMIT = TIMEOUT - 24'd1;
   localparam logic [23:0]   WD_MAX   = 24'hFFFFFF;

   localparam logic [NUM_CARS-1:0] EN_ONE = {{(NUM_CARS-1){1'b0}}, 1'b1};

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE    = 3'd1;
   localparam logic [2:0] S_WAIT_FIN = 3'd2;
   localparam logic [2:0] S_NEXT     = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_nxt;
   logic [23:0]   wd;
   logic          fin_cur;
   logic          wd_hit;
   logic          to_set;

   // Only the finish bit of the engine being served matters.
   always_comb begin
      fin_cur = finish_in[idx];
   end

   // Watchdog limit reached; a finish in the same cycle wins.
   always_comb begin
      wd_hit = (wd == WD_LIMIT);
      to_set = (state == S_WAIT_FIN) && !fin_cur && wd_hit;
   end

   // Next-state and next-index logic.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_ISSUE;
               idx_nxt   = '0;
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT_FIN;
         end
         S_WAIT_FIN: begin
            if (fin_cur || wd_hit) begin
               state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx == LAST_IDX) begin
               state_nxt = S_DONE;
            end else begin
               idx_nxt   = idx + 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_DONE: begin
            if (start) begin
               state_nxt = S_ISSUE;
               idx_nxt   = '0;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // State and engine index registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Watchdog: cleared on issue, counts while waiting, saturates.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd <= '0;
      end else if (state == S_ISSUE) begin
         wd <= '0;
      end else if (state == S_WAIT_FIN && wd != WD_MAX) begin
         wd <= wd + 24'd1;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timeout_err <= 1'b0;
      end else if (to_set) begin
         timeout_err <= 1'b1;
      end
   end

   // One-hot EN pulse while issuing; status flags from state.
   always_comb begin
      en_out     = (state == S_ISSUE) ? (EN_ONE << idx) : '0;
      busy       = (state != S_IDLE);
      frame_done = (state == S_DONE);
      active_idx = 3'(idx);
   end

   // Pixel bus follows the served engine only while waiting on it.
   always_comb begin
      plot   = 1'b0;
      x      = '0;
      y      = '0;
      colour = '0;
      if (state == S_WAIT_FIN) begin
         for (int i = 0; i < NUM_CARS; i++) begin
            if (idx == IW'(i)) begin
               plot   = plot_in[i];
               x      = x_in[8*i +: 8];
               y      = y_in[7*i +: 7];
               colour = colour_in[3*i +: 3];
            end
         end
      end
   end

endmodule

// File: tb/tb_car_draw_scheduler.sv
// tb_car_draw_scheduler: directed bench for car_draw_scheduler.
// Engine models answer EN after a programmable delay (0 = never).
module tb_car_draw_scheduler;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [3:0]  finish_in;
   logic [3:0]  plot_in;
   logic [31:0] x_in;
   logic [27:0] y_in;
   logic [11:0] colour_in;
   logic [3:0]  en_out;
   logic        plot;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic [2:0]  active_idx;
   logic        busy;
   logic        frame_done;
   logic        timeout_err;

   logic [3:0]  eng_fin;
   logic [3:0]  stray_fin;
   int          dly [4];
   int          cnt [4];
   int          cyc;
   int          n_chk;
   int          n_err;
   int          fd_cnt;
   int          en_cnt;
   logic        onehot_bad;

   assign finish_in = eng_fin | stray_fin;

   car_draw_scheduler #(
      .NUM_CARS (4),
      .TIMEOUT  (24'd100)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .finish_in   (finish_in),
      .plot_in     (plot_in),
      .x_in        (x_in),
      .y_in        (y_in),
      .colour_in   (colour_in),
      .en_out      (en_out),
      .plot        (plot),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .active_idx  (active_idx),
      .busy        (busy),
      .frame_done  (frame_done),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Engine models: finish pulse seen dly cycles after EN.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!resetn) begin
            cnt[i] = 0;
            eng_fin[i] = 1'b0;
         end else if (en_out[i]) begin
            cnt[i] = dly[i];
            eng_fin[i] = 1'b0;
         end else if (cnt[i] > 0) begin
            cnt[i] = cnt[i] - 1;
            eng_fin[i] = (cnt[i] == 0);
         end else begin
            eng_fin[i] = 1'b0;
         end
      end
   end

   // Monitor: count EN pulses and frame_done pulses, watch one-hot.
   always @(negedge clk) begin
      if (en_out != 4'b0) en_cnt = en_cnt + 1;
      if ($countones(en_out) > 1) onehot_bad = 1'b1;
      if (frame_done) fd_cnt = fd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_en(input string tag, input logic [3:0] pat,
                          output int at);
      int n;
      n = 0;
      while (en_out !== pat && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(en_out), 32'(pat));
      at = cyc;
   endtask

   task automatic wait_fd(input string tag, output int at);
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(frame_done), 32'd1);
      at = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

   initial begin
      int t0, t1, t2, t3, td, snap, fsnap, n;

      cyc = 0; n_chk = 0; n_err = 0;
      fd_cnt = 0; en_cnt = 0; onehot_bad = 1'b0;
      stray_fin = 4'b0; eng_fin = 4'b0;
      for (int i = 0; i < 4; i++) begin
         dly[i] = 50;
         cnt[i] = 0;
      end
      plot_in   = 4'b0100;
      x_in      = {8'd30, 8'd105, 8'd20, 8'd10};
      y_in      = {7'd3, 7'd60, 7'd2, 7'd1};
      colour_in = {3'b001, 3'b110, 3'b011, 3'b101};
      start  = 1'b0;
      resetn = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_en", 32'(en_out), 0);
      chk("rst_fd", 32'(frame_done), 0);
      chk("rst_to", 32'(timeout_err), 0);
      chk("rst_idx", 32'(active_idx), 0);
      chk("rst_plot", 32'(plot), 0);

      resetn = 1'b1;
      start  = 1'b1;

      wait_en("f1_en0", 4'b0001, t0);
      wait_en("f1_en1", 4'b0010, t1);
      chk("f1_gap01", t1 - t0, 52);
      wait_en("f1_en2", 4'b0100, t2);
      chk("f1_gap12", t2 - t1, 52);
      @(negedge clk);
      chk("mux_plot", 32'(plot), 1);
      chk("mux_x", 32'(x), 105);
      chk("mux_y", 32'(y), 60);
      chk("mux_col", 32'(colour), 6);
      chk("mux_idx", 32'(active_idx), 2);
      repeat (50) @(negedge clk);
      chk("next_plot", 32'(plot), 0);
      chk("next_x", 32'(x), 0);
      chk("next_y", 32'(y), 0);
      chk("next_col", 32'(colour), 0);
      chk("next_en", 32'(en_out), 0);
      chk("next_busy", 32'(busy), 1);
      wait_en("f1_en3", 4'b1000, t3);
      chk("f1_gap23", t3 - t2, 52);
      wait_fd("f1_fd", td);
      chk("f1_fd_lat", td - t3, 52);
      @(negedge clk);
      chk("f2_back2back", 32'(en_out), 1);
      chk("f1_fd_cnt", fd_cnt, 1);
      t0 = cyc;

      stray_fin = 4'b0001;
      @(negedge clk);
      stray_fin = 4'b1000;
      repeat (5) @(negedge clk);
      chk("stray_idx", 32'(active_idx), 0);
      chk("stray_busy", 32'(busy), 1);
      chk("stray_en", 32'(en_out), 0);
      stray_fin = 4'b0;
      wait_en("f2_en1", 4'b0010, t1);
      chk("stray_gap", t1 - t0, 52);

      start = 1'b0;
      wait_en("f2_en2", 4'b0100, t2);
      wait_en("f2_en3", 4'b1000, t3);
      wait_fd("f2_fd", td);
      @(negedge clk);
      chk("stop_busy", 32'(busy), 0);
      chk("stop_fd", 32'(frame_done), 0);
      snap = en_cnt;
      repeat (20) @(negedge clk);
      chk("stop_noen", en_cnt, snap);
      chk("stop_idle", 32'(busy), 0);
      chk("f2_fd_cnt", fd_cnt, 2);

      dly[1] = 100;
      start = 1'b1;
      wait_en("f3_en0", 4'b0001, t0);
      wait_en("f3_en1", 4'b0010, t1);
      wait_en("f3_en2", 4'b0100, t2);
      chk("tie_gap", t2 - t1, 102);
      chk("tie_noerr", 32'(timeout_err), 0);
      dly[1] = 0;

      wait_en("f3_en3", 4'b1000, t3);
      wait_fd("f3_fd", td);
      wait_en("f4_en0", 4'b0001, t0);
      wait_en("f4_en1", 4'b0010, t1);
      chk("to_pre", 32'(timeout_err), 0);
      wait_en("f4_en2", 4'b0100, t2);
      chk("to_gap", t2 - t1, 102);
      chk("to_set", 32'(timeout_err), 1);
      @(negedge clk);
      chk("to_sticky", 32'(timeout_err), 1);
      chk("to_wait_plot", 32'(plot), 1);

      fsnap = fd_cnt;
      resetn = 1'b0;
      #1;
      chk("mrst_en", 32'(en_out), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_plot", 32'(plot), 0);
      chk("mrst_x", 32'(x), 0);
      chk("mrst_y", 32'(y), 0);
      chk("mrst_col", 32'(colour), 0);
      chk("mrst_fd", 32'(frame_done), 0);
      chk("mrst_to", 32'(timeout_err), 0);
      chk("mrst_idx", 32'(active_idx), 0);
      repeat (3) @(negedge clk);
      dly[1] = 50;
      resetn = 1'b1;
      n = 0;
      while (en_out == 4'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("mrst_first", 32'(en_out), 1);
      chk("mrst_nofd", fd_cnt, fsnap);
      chk("onehot", 32'(onehot_bad), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
